// File: rtl/booth_pp_gen_pkg.sv
// ============================================================================
// booth_pp_gen_pkg : shared sizes, Booth select triple, partial-product helper
// Rev 1.0
// ============================================================================
`default_nettype none

package booth_pp_gen_pkg;

  localparam int PP_NUM = 8;
  localparam int COL_W  = 32;
  localparam int OP_W   = 16;
  localparam int N_W    = PP_NUM * COL_W;

  typedef struct packed {
    logic one;
    logic two;
    logic neg;
  } booth_sel_t;

  // Unshifted row: |d|*x as 17-bit signed, inverted for negative digits, sign-extended.
  function automatic logic [COL_W-1:0] pp_row(input logic [OP_W-1:0] xv, input booth_sel_t sel);
    logic [OP_W:0] mag;
    mag = '0;
    if (sel.one) begin
      mag = {xv[OP_W-1], xv};
    end else if (sel.two) begin
      mag = {xv, 1'b0};
    end
    if (sel.neg) begin
      mag = ~mag;
    end
    return {{(COL_W-OP_W-1){mag[OP_W]}}, mag};
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_enc.sv
// ============================================================================
// booth_enc : radix-4 Booth window (y[2i+1], y[2i], y[2i-1]) -> select triple
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_enc
  import booth_pp_gen_pkg::*;
(
  input  logic [2:0]  win,
  output booth_sel_t  sel
);

  // 111 is a zero digit, so it must not raise neg.
  always_comb begin
    sel     = '0;
    sel.one = win[1] ^ win[0];
    sel.two = (win == 3'b100) || (win == 3'b011);
    sel.neg = win[2] && !(win[1] && win[0]);
  end

endmodule

`default_nettype wire

// File: rtl/booth_pp_gen.sv
// ============================================================================
// booth_pp_gen : radix-4 Booth partial-product generator, column-major output
// Define BOOTH_PIPE2_EN for a two-stage (encode / form) pipeline.
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_pp_gen
  import booth_pp_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    x,
  input  logic [OP_W-1:0]    y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_W-1:0]     col_n,
  output logic [PP_NUM-1:0]  neg
);

  logic [OP_W:0]                 y_ext;
  booth_sel_t [PP_NUM-1:0]       enc_sel;
  logic [OP_W-1:0]               pp_x;
  booth_sel_t [PP_NUM-1:0]       pp_sel;
  logic [COL_W-1:0]              row_w;
  logic [N_W-1:0]                col_w;
  logic [PP_NUM-1:0]             neg_w;
  logic                          load_out;

  logic                          out_valid_q, out_valid_d;
  logic [N_W-1:0]                col_q, col_d;
  logic [PP_NUM-1:0]             neg_q, neg_d;

  assign y_ext = {y, 1'b0};

  generate
    for (genvar gi = 0; gi < PP_NUM; gi++) begin : g_enc
      booth_enc u_enc (
        .win (y_ext[2*gi+2 -: 3]),
        .sel (enc_sel[gi])
      );
    end
  endgenerate

`ifdef BOOTH_PIPE2_EN
  logic                      s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]           s1_x_q, s1_x_d;
  booth_sel_t [PP_NUM-1:0]   s1_sel_q, s1_sel_d;
  logic                      out_stage_ready;
  logic                      accept;

  // Each stage moves when its successor is empty or draining this cycle.
  always_comb begin
    out_stage_ready = !out_valid_q || out_ready;
    in_ready        = !s1_valid_q || out_stage_ready;
    accept          = in_valid && in_ready;
    load_out        = s1_valid_q && out_stage_ready;
    s1_valid_d      = s1_valid_q;
    s1_x_d          = s1_x_q;
    s1_sel_d        = s1_sel_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = x;
      s1_sel_d   = enc_sel;
    end else if (load_out) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_sel_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_sel_q   <= s1_sel_d;
    end
  end

  assign pp_x   = s1_x_q;
  assign pp_sel = s1_sel_q;
`else
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    load_out = in_valid && in_ready;
  end

  assign pp_x   = x;
  assign pp_sel = enc_sel;
`endif

  // Scatter row i bit k to col_n[PP_NUM*k + i] so each column is one contiguous byte.
  always_comb begin
    col_w = '0;
    neg_w = '0;
    row_w = '0;
    for (int i = 0; i < PP_NUM; i++) begin
      row_w    = pp_row(pp_x, pp_sel[i]) << (2*i);
      neg_w[i] = pp_sel[i].neg;
      for (int k = 0; k < COL_W; k++) begin
        col_w[PP_NUM*k + i] = row_w[k];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    col_d       = col_q;
    neg_d       = neg_q;
    if (load_out) begin
      out_valid_d = 1'b1;
      col_d       = col_w;
      neg_d       = neg_w;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      col_q       <= '0;
      neg_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      col_q       <= col_d;
      neg_q       <= neg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign col_n     = col_q;
  assign neg       = neg_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_pp_gen.sv
// ============================================================================
// tb_booth_pp_gen : directed vectors, handshake corners and random stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_booth_pp_gen;

`ifdef BOOTH_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  x;
  logic [15:0]  y;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] col_n;
  logic [7:0]   neg;

  booth_pp_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .col_n     (col_n),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  exp_neg;
    logic [31:0] exp_res;
  } vec_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } op_t;

  vec_t vecs [8];
  op_t  sbq [$];
  op_t  mon_e;
  logic mon_en = 1'b0;
  logic held = 1'b0;
  logic [255:0] held_col;
  logic [7:0]   held_neg;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Digit value straight from the recoding rule, then |d|*x as a 17-bit field.
  function automatic int digit(input logic [15:0] yv, input int i);
    int d;
    d = 0;
    if (yv[2*i])              d += 1;
    if (i > 0 && yv[2*i-1])   d += 1;
    if (yv[2*i+1])            d -= 2;
    return d;
  endfunction

  function automatic logic [31:0] model_pp(input logic [15:0] xv, input logic [15:0] yv, input int i);
    int d;
    longint p;
    logic [16:0] m;
    logic [31:0] r;
    d = digit(yv, i);
    p = longint'($signed(xv)) * longint'(d < 0 ? -d : d);
    m = p[16:0];
    if (d < 0) m = ~m;
    r = {{15{m[16]}}, m};
    return r << (2*i);
  endfunction

  function automatic logic [255:0] model_cols(input logic [15:0] xv, input logic [15:0] yv);
    logic [255:0] c;
    logic [31:0]  p;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      p = model_pp(xv, yv, i);
      for (int k = 0; k < 32; k++) c[8*k+i] = p[k];
    end
    return c;
  endfunction

  function automatic logic [7:0] model_neg(input logic [15:0] yv);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) n[i] = (digit(yv, i) < 0);
    return n;
  endfunction

  function automatic logic [31:0] col_sum(input logic [255:0] c, input logic [7:0] ng);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 32; k++)
      for (int i = 0; i < 8; i++)
        if (c[8*k+i]) s = s + (32'd1 << k);
    for (int i = 0; i < 8; i++)
      if (ng[i]) s = s + (32'd1 << (2*i));
    return s;
  endfunction

  function automatic logic [31:0] prod(input logic [15:0] xv, input logic [15:0] yv);
    int p;
    p = int'($signed(xv)) * int'($signed(yv));
    return p;
  endfunction

  // Scoreboard monitor for the random phase.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        sbq.delete();
        held = 1'b0;
      end else begin
        if (out_valid) begin
          if (held) begin
            chk("hold_col", col_n, held_col);
            chk("hold_neg", {248'd0, neg}, {248'd0, held_neg});
          end
          if (out_ready) begin
            if (sbq.size() == 0) begin
              chk("unexpected_out", 1, 0);
            end else begin
              mon_e = sbq.pop_front();
              chk("rand_col", col_n, model_cols(mon_e.x, mon_e.y));
              chk("rand_neg", {248'd0, neg}, {248'd0, model_neg(mon_e.y)});
              chk("rand_prod", {224'd0, col_sum(col_n, neg)}, {224'd0, prod(mon_e.x, mon_e.y)});
            end
            held = 1'b0;
          end else begin
            held     = 1'b1;
            held_col = col_n;
            held_neg = neg;
          end
        end
        if (in_valid && in_ready) sbq.push_back('{x: x, y: y});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    in_valid  = 1'b1;
    x         = v.x;
    y         = v.y;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT-1) begin @(posedge clk); #1; end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_neg"}, neg, v.exp_neg);
    chk({nm, "_sum"}, col_sum(col_n, neg), v.exp_res);
    chk({nm, "_cols"}, col_n, model_cols(v.x, v.y));
  endtask

  logic [255:0] saved_col;
  vec_t a_v, b_v;

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 8'h00, 32'h0000000F};
    vecs[1] = '{16'h8000, 16'h8000, 8'h80, 32'h40000000};
    vecs[2] = '{16'hFFFF, 16'h0001, 8'h00, 32'hFFFFFFFF};
    vecs[3] = '{16'h1234, 16'hFFFF, 8'h01, 32'hFFFFEDCC};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 8'h01, 32'h3FFF0001};
    vecs[5] = '{16'h0000, 16'hAAAA, 8'hFF, 32'h00000000};
    vecs[6] = '{16'h8000, 16'h7FFF, 8'h01, 32'hC0008000};
    vecs[7] = '{16'h0001, 16'h8000, 8'h80, 32'hFFFF8000};

    rst = 1'b1; in_valid = 1'b1; x = 16'h1111; y = 16'h2222; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("reset_valid", out_valid, 0);
    chk("reset_col", col_n, 0);
    chk("reset_neg", neg, 0);
    chk("reset_ready", in_ready, 1);

    for (int v = 0; v < 8; v++) apply_vec(vecs[v], $sformatf("vec%0d", v));

    // Back-to-back stream: first output LAT-1 edges after first accept, then one per cycle.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; x = vecs[0].x; y = vecs[0].y;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ready%0d", j), in_ready, 1);
      if (j < 3) begin x = vecs[j+1].x; y = vecs[j+1].y; end
      else in_valid = 1'b0;
      if (j >= LAT-1 && j < LAT-1+4) begin
        chk($sformatf("b2b_valid%0d", j), out_valid, 1);
        chk($sformatf("b2b_cols%0d", j), col_n, model_cols(vecs[j-LAT+1].x, vecs[j-LAT+1].y));
      end else begin
        chk($sformatf("b2b_valid%0d", j), out_valid, 0);
      end
    end

`ifndef BOOTH_PIPE2_EN
    // Backpressure: second set waits while the first is stalled.
    a_v = vecs[3]; b_v = vecs[6];
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; x = a_v.x; y = a_v.y;
    @(posedge clk); #1;
    x = b_v.x; y = b_v.y;
    chk("bp_valid", out_valid, 1);
    chk("bp_ready0", in_ready, 0);
    chk("bp_colA", col_n, model_cols(a_v.x, a_v.y));
    saved_col = col_n;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_stall_ready%0d", c), in_ready, 0);
      chk($sformatf("bp_stall_col%0d", c), col_n, saved_col);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready1", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_validB", out_valid, 1);
    chk("bp_colB", col_n, model_cols(b_v.x, b_v.y));
    chk("bp_negB", neg, b_v.exp_neg);
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);
    chk("bp_hold_last", col_n, model_cols(b_v.x, b_v.y));
`endif

    // Reset while a set is waiting on downstream.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; x = vecs[4].x; y = vecs[4].y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT-1) begin @(posedge clk); #1; end
    chk("rm_pre_valid", out_valid, 1);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rm_valid", out_valid, 0);
    chk("rm_col", col_n, 0);
    chk("rm_neg", neg, 0);
    chk("rm_ready", in_ready, 1);
    repeat (LAT) @(posedge clk);
    #1;
    chk("rm_ignored_input", out_valid, 0);

    // Random stream with stalls and occasional reset.
    mon_en = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(999) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      case ($urandom_range(7))
        0:       x = 16'h8000;
        1:       x = 16'h7FFF;
        2:       x = 16'hFFFF;
        default: x = 16'($urandom);
      endcase
      case ($urandom_range(7))
        0:       y = 16'h8000;
        1:       y = 16'hFFFF;
        2:       y = 16'hAAAA;
        default: y = 16'($urandom);
      endcase
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("drain_empty", sbq.size(), 0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
